// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants: scheduler state type, coordinate width, screen
// geometry and the initial pipe layout reused by collision and display logic.
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} sched_state_t;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int PIPE_W   = 40;
    localparam int BIRD_X   = 100;

    localparam logic [COORD_W-1:0] PIPE1_X_INIT = 11'd319;
    localparam logic [COORD_W-1:0] PIPE2_X_INIT = 11'd639;
    localparam logic [COORD_W-1:0] PIPE1_Y_INIT = 11'd250;
    localparam logic [COORD_W-1:0] PIPE2_Y_INIT = 11'd200;
    localparam logic [2:0]         SPEED_INIT   = 3'd1;

endpackage

// File: rtl/pipe_lane.sv
// One scrolling pipe: x/y registers, recycle-or-move step, gap mapping and
// detection of the move that carries the pipe past the bird.
module pipe_lane
    import flappy_pkg::COORD_W;
#(
    parameter int                 SCREEN_W = 640,
    parameter int                 PIPE_W   = 40,
    parameter int                 BIRD_X   = 100,
    parameter int                 GAP_MIN  = 80,
    parameter int                 GAP_MAX  = 380,
    parameter logic [COORD_W-1:0] X_INIT   = '0,
    parameter logic [COORD_W-1:0] Y_INIT   = '0
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               load,
    input  logic               move,
    input  logic [2:0]         speed,
    input  logic [8:0]         r,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               scored
);

    localparam int                 GAP_SPAN  = GAP_MAX - GAP_MIN + 1;
    localparam logic [COORD_W-1:0] RECYCLE_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] SCORE_X   = COORD_W'(BIRD_X - PIPE_W);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_speed_ext;
    logic [COORD_W-1:0] w_x_step;
    logic [COORD_W-1:0] w_gap;
    logic [8:0]         w_r_wrapped;
    logic               w_recycle;

    assign w_speed_ext = COORD_W'(speed);
    assign w_recycle   = r_x <= w_speed_ext;
    assign w_x_step    = r_x - w_speed_ext;

    // r is at most 511, below twice the span, so a single subtract folds it in range
    assign w_r_wrapped = (r >= 9'(GAP_SPAN)) ? r - 9'(GAP_SPAN) : r;
    assign w_gap       = COORD_W'(GAP_MIN) + COORD_W'(w_r_wrapped);

    assign scored = move && !w_recycle && (r_x >= SCORE_X) && (w_x_step < SCORE_X);
    assign x      = r_x;
    assign y      = r_y;

    always_ff @(posedge game_clk) begin
        if (reset || load) begin
            r_x <= X_INIT;
            r_y <= Y_INIT;
        end else if (move) begin
            if (w_recycle) begin
                r_x <= RECYCLE_X;
                r_y <= w_gap;
            end else begin
                r_x <= w_x_step;
            end
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe obstacle scheduler: run/halt FSM, two pipe lanes, saturating score and
// score-driven scroll speed.
//   state | meaning
//   IDLE  | initial layout loaded, waiting for enable
//   RUN   | pipes scroll while enable is high; collision freezes the game
//   HALT  | frozen after a collision until restart or reset
module pipe_scheduler
    import flappy_pkg::COORD_W, flappy_pkg::sched_state_t, flappy_pkg::IDLE,
           flappy_pkg::RUN, flappy_pkg::HALT, flappy_pkg::PIPE1_X_INIT,
           flappy_pkg::PIPE2_X_INIT, flappy_pkg::PIPE1_Y_INIT,
           flappy_pkg::PIPE2_Y_INIT, flappy_pkg::SPEED_INIT;
#(
    parameter int SCREEN_W       = flappy_pkg::SCREEN_W,
    parameter int PIPE_W         = flappy_pkg::PIPE_W,
    parameter int BIRD_X         = flappy_pkg::BIRD_X,
    parameter int GAP_MIN        = 80,
    parameter int GAP_MAX        = 380,
    parameter int SPEED_STEP_PTS = 10,
    parameter int MAX_SPEED      = 4
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    input  logic               collision,
    input  logic [9:0]         random,
    output logic [COORD_W-1:0] pipe1_x,
    output logic [COORD_W-1:0] pipe2_x,
    output logic [COORD_W-1:0] pipe1_y,
    output logic [COORD_W-1:0] pipe2_y,
    output logic [9:0]         score,
    output logic               score_pulse,
    output logic [2:0]         speed,
    output logic               running
);

    localparam logic [9:0] SCORE_MAX = 10'd999;
    localparam logic [9:0] STEP      = 10'(SPEED_STEP_PTS);

    sched_state_t r_state;
    logic [9:0]   r_score;
    logic [2:0]   r_speed;
    logic         r_pulse;
    logic         w_move;
    logic         w_scored1;
    logic         w_scored2;
    logic [10:0]  w_sum;
    logic [9:0]   w_score_next;
    logic         w_step_cross;
    logic         w_unused_rand_msb;

    assign w_move            = (r_state == RUN) && enable && !collision;
    assign w_unused_rand_msb = random[9];

    pipe_lane #(
        .SCREEN_W(SCREEN_W), .PIPE_W(PIPE_W), .BIRD_X(BIRD_X),
        .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX),
        .X_INIT(PIPE1_X_INIT), .Y_INIT(PIPE1_Y_INIT)
    ) u_lane1 (
        .game_clk(game_clk), .reset(reset), .load(restart), .move(w_move),
        .speed(r_speed), .r(random[8:0]),
        .x(pipe1_x), .y(pipe1_y), .scored(w_scored1)
    );

    // Bit-rotated draw so two pipes recycling together get different gaps
    pipe_lane #(
        .SCREEN_W(SCREEN_W), .PIPE_W(PIPE_W), .BIRD_X(BIRD_X),
        .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX),
        .X_INIT(PIPE2_X_INIT), .Y_INIT(PIPE2_Y_INIT)
    ) u_lane2 (
        .game_clk(game_clk), .reset(reset), .load(restart), .move(w_move),
        .speed(r_speed), .r({random[3:0], random[8:4]}),
        .x(pipe2_x), .y(pipe2_y), .scored(w_scored2)
    );

    assign w_sum        = 11'(r_score) + 11'(w_scored1) + 11'(w_scored2);
    assign w_score_next = (w_sum > 11'(SCORE_MAX)) ? SCORE_MAX : w_sum[9:0];
    assign w_step_cross = (w_score_next / STEP) != (r_score / STEP);

    always_ff @(posedge game_clk) begin
        if (reset || restart) begin
            r_state <= IDLE;
            r_score <= '0;
            r_speed <= SPEED_INIT;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: if (enable) r_state <= RUN;
                RUN: begin
                    if (collision) begin
                        r_state <= HALT;
                    end else if (enable) begin
                        r_score <= w_score_next;
                        r_pulse <= w_scored1 || w_scored2;
                        if (w_step_cross && (r_speed < 3'(MAX_SPEED)))
                            r_speed <= r_speed + 3'd1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign score       = r_score;
    assign score_pulse = r_pulse;
    assign speed       = r_speed;
    assign running     = (r_state == RUN);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: a full-size instance for layout, motion,
// gap mapping, collision and restart; a 65-pixel-wide instance for fast scoring runs.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        reset, enable, restart, collision;
    logic [9:0]  random;
    logic [10:0] p1x, p2x, p1y, p2y;
    logic [9:0]  score;
    logic        pulse, running;
    logic [2:0]  speed;

    logic        s_reset, s_enable, s_restart, s_collision;
    logic [9:0]  s_random;
    logic [10:0] s_p1x, s_p2x, s_p1y, s_p2y;
    logic [9:0]  s_score;
    logic        s_pulse, s_running;
    logic [2:0]  s_speed;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .game_clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .collision(collision), .random(random),
        .pipe1_x(p1x), .pipe2_x(p2x), .pipe1_y(p1y), .pipe2_y(p2y),
        .score(score), .score_pulse(pulse), .speed(speed), .running(running)
    );

    pipe_scheduler #(.SCREEN_W(65)) dut_s (
        .game_clk(clk), .reset(s_reset), .enable(s_enable), .restart(s_restart),
        .collision(s_collision), .random(s_random),
        .pipe1_x(s_p1x), .pipe2_x(s_p2x), .pipe1_y(s_p1y), .pipe2_y(s_p2y),
        .score(s_score), .score_pulse(s_pulse), .speed(s_speed), .running(s_running)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs,
                           input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected range %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_s_score(input int target, input int budget);
        for (int i = 0; i < budget && s_score < 10'(target); i++) tick(1);
    endtask

    initial begin
        reset = 1; enable = 0; restart = 0; collision = 0; random = 10'h1FF;
        s_reset = 1; s_enable = 0; s_restart = 0; s_collision = 0; s_random = 10'h155;
        tick(2);
        chk("rst_pipe1_x", p1x, 319);
        chk("rst_pipe2_x", p2x, 639);
        chk("rst_pipe1_y", p1y, 250);
        chk("rst_pipe2_y", p2y, 200);
        chk("rst_score", score, 0);
        chk("rst_speed", speed, 1);
        chk("rst_pulse", pulse, 0);
        chk("rst_running", running, 0);

        // Entering RUN takes one tick without motion; moves are counted from there
        reset = 0; enable = 1;
        tick(1);
        chk("enter_running", running, 1);
        chk("enter_no_move", p1x, 319);
        tick(5);
        chk("run5_pipe1_x", p1x, 314);
        chk("run5_pipe2_x", p2x, 634);
        chk("run5_speed", speed, 1);

        enable = 0;
        tick(3);
        chk("pause_pipe1_x", p1x, 314);
        chk("pause_pipe2_x", p2x, 634);
        chk("pause_running", running, 1);
        enable = 1;

        tick(253);
        chk("m258_pipe1_x", p1x, 61);
        chk("m258_pipe2_x", p2x, 381);
        tick(1);
        chk("m259_pipe1_x", p1x, 60);
        chk("m259_pulse", pulse, 0);
        chk("m259_score", score, 0);
        tick(1);
        chk("m260_pipe1_x", p1x, 59);
        chk("m260_pulse", pulse, 1);
        chk("m260_score", score, 1);
        tick(1);
        chk("m261_pulse", pulse, 0);
        chk("m261_score", score, 1);

        tick(57);
        chk("m318_pipe1_x_eq_speed", p1x, 1);
        tick(1);
        chk("m319_recycle_x", p1x, 639);
        chk("m319_recycle_y_1ff", p1y, 290);
        chk("m319_pipe2_x", p2x, 320);
        chk("m319_pipe2_y_kept", p2y, 200);

        random = 10'h155;
        tick(320);
        chk("m639_pipe2_x", p2x, 639);
        chk("m639_pipe2_y_155", p2y, 261);
        chk("m639_pipe1_x", p1x, 319);
        chk("m639_score", score, 2);

        random = 10'h12C;
        tick(319);
        chk("m958_pipe1_x", p1x, 639);
        chk("m958_pipe1_y_max", p1y, 380);

        random = 10'h12D;
        tick(639);
        chk("m1597_pipe1_x", p1x, 639);
        chk("m1597_pipe1_y_min", p1y, 80);

        tick(1538);
        chk("m3135_score", score, 9);
        chk("m3135_speed", speed, 1);
        tick(1);
        chk("m3136_score", score, 10);
        chk("m3136_speed", speed, 2);
        chk("m3136_pulse", pulse, 1);
        chk("m3136_pipe1_x", p1x, 378);
        chk("m3136_pipe2_x", p2x, 59);
        tick(1);
        chk("m3137_pipe1_x_spd2", p1x, 376);
        chk("m3137_pipe2_x_spd2", p2x, 57);

        collision = 1;
        tick(1);
        chk("coll_running", running, 0);
        chk("coll_pipe1_x", p1x, 376);
        chk("coll_pipe2_x", p2x, 57);
        chk("coll_score", score, 10);
        chk("coll_pulse", pulse, 0);
        collision = 0;
        tick(10);
        chk("halt_pipe1_x", p1x, 376);
        chk("halt_pipe2_x", p2x, 57);
        chk("halt_running", running, 0);
        chk("halt_score", score, 10);

        restart = 1;
        tick(2);
        chk("rs_pipe1_x", p1x, 319);
        chk("rs_pipe2_x", p2x, 639);
        chk("rs_pipe1_y", p1y, 250);
        chk("rs_pipe2_y", p2y, 200);
        chk("rs_score", score, 0);
        chk("rs_speed", speed, 1);
        chk("rs_running", running, 0);
        restart = 0;
        tick(1);
        chk("rs_resume_running", running, 1);
        chk("rs_resume_x", p1x, 319);
        tick(1);
        chk("rs_first_move", p1x, 318);

        reset = 1;
        tick(1);
        chk("midrst_pipe1_x", p1x, 319);
        chk("midrst_running", running, 0);
        enable = 0;

        // Narrow screen: pipes recycle to 64, align at move 639 and then score in pairs
        s_reset = 0; s_enable = 1;
        tick(1);
        chk("s_running", s_running, 1);
        tick(579);
        chk("s_m579_score", s_score, 5);
        tick(1);
        chk("s_m580_score_plus2", s_score, 7);
        chk("s_m580_pulse", s_pulse, 1);
        tick(59);
        chk("s_m639_pipe1_x", s_p1x, 64);
        chk("s_m639_pipe2_x", s_p2x, 64);
        chk("s_m639_pipe1_y", s_p1y, 120);
        chk("s_m639_pipe2_y", s_p2y, 261);
        chk("s_m639_score", s_score, 7);

        wait_s_score(9, 200);
        chk("s_score9", s_score, 9);
        chk("s_score9_speed", s_speed, 1);
        wait_s_score(11, 200);
        chk("s_score11", s_score, 11);
        chk("s_score11_speed_once", s_speed, 2);
        wait_s_score(21, 400);
        chk("s_score21", s_score, 21);
        chk("s_score21_speed", s_speed, 3);
        wait_s_score(31, 400);
        chk("s_score31", s_score, 31);
        chk("s_score31_speed", s_speed, 4);
        wait_s_score(41, 400);
        chk("s_score41", s_score, 41);
        chk("s_score41_speed_cap", s_speed, 4);

        for (int i = 0; i < 20000 && s_score < 10'd999; i++) begin
            s_random = 10'(i * 7);
            tick(1);
            chk_rng("s_pipe1_y_range", s_p1y, 80, 380);
            chk_rng("s_pipe2_y_range", s_p2y, 80, 380);
        end
        chk("s_score999", s_score, 999);
        chk("s_speed_final", s_speed, 4);

        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            tick(1);
            if (s_pulse === 1'b1) seen = 1;
        end
        chk("s_sat_pulse_seen", seen, 1);
        chk("s_score_saturated", s_score, 999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequences the two scrolling pipe obstacles of the Flappy Bird game on the game tick: advances their x coordinates at the current scroll speed and recycles each pipe independently at the left edge with a fresh gap height from the 10-bit LFSR. It also scores each pipe the bird clears and raises scroll speed as the score grows. It sits between `game_manager` (enable/restart), the LFSR, and the `collision_detector`/`display_manager` consumers of pipe coordinates.

## Interface
Parameters:
- `SCREEN_W`, 640: horizontal resolution; the recycle position is `SCREEN_W-1`.
- `PIPE_W`, 40: pipe width in pixels.
- `BIRD_X`, 100: fixed bird x.
- `GAP_MIN`, 80: smallest gap y.
- `GAP_MAX`, 380: largest gap y.
- `SPEED_STEP_PTS`, 10: points per speed increment.
- `MAX_SPEED`, 4: speed ceiling in pixels/tick.

Ports:
- `game_clk` in 1: game tick clock. Reset is synchronous, active-high, on `game_clk`.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: motion permitted (from `game_manager`).
- `restart` in 1: reload initial layout; level-sampled on `game_clk`.
- `collision` in 1: bird hit detected.
- `random` in 10: LFSR value.
- `pipe1_x`, `pipe2_x` out 11: pipe left-edge x.
- `pipe1_y`, `pipe2_y` out 11: gap y.
- `score` out 10: binary, saturates at 999.
- `score_pulse` out 1: one-tick pulse per scoring tick.
- `speed` out 3: current pixels/tick.
- `running` out 1: state == RUN.

## Operation
- States: IDLE, RUN, HALT.
  - `reset` or `restart` from any state → IDLE with initial layout; `reset` has priority.
  - IDLE & `enable` → RUN.
  - RUN & `collision` → HALT. Collision has priority over motion in the same tick: that tick produces no move and no score.
  - HALT is left only by `restart` or `reset`.
  - In RUN with `enable` low, the block holds all values (pause).
- Initial layout (reset value of every output): `pipe1_x`=319, `pipe2_x`=639, `pipe1_y`=250, `pipe2_y`=200, `score`=0, `speed`=1, `score_pulse`=0, `running`=0.
- Motion, in RUN & `enable` & ~`collision`, per pipe independently:
  - If `x <= speed`: recycle. `x ← SCREEN_W-1`, `y ← gap(r)`.
  - Otherwise `x ← x - speed`. Unsigned underflow is never allowed.
- Gap mapping, with `R = GAP_MAX-GAP_MIN+1` (301):
  - `r1 = random[8:0]` for pipe1.
  - `r2 = {random[3:0], random[8:4]}` for pipe2, so that pipes recycling in the same tick differ.
  - `gap = GAP_MIN + (r ≥ R ? r-R : r)`. This single conditional subtract suffices because r ≤ 511 < 2R. The result is always in [GAP_MIN, GAP_MAX].
- Scoring:
  - A pipe scores when its old x ≥ `BIRD_X-PIPE_W` and its new x < `BIRD_X-PIPE_W` in a non-recycling move.
  - `score` adds the number of scoring pipes (0–2), saturating at 999.
  - `score_pulse` = 1 for the tick in which any pipe scored.
- Speed:
  - After a score update, if `score` crossed a multiple of `SPEED_STEP_PTS`, `speed` increments, saturating at `MAX_SPEED`.
  - A +2 update crossing one boundary increments once.
  - `speed` resets to 1 only on reset/restart.

## Timing
- All outputs are registered on `game_clk`. Each output reflects inputs sampled at the previous edge (1-tick latency).
- `score_pulse` lasts exactly one tick and is 0 in IDLE and HALT.
- The new `speed` takes effect on the move of the tick after it updates.
- `restart` held for multiple ticks keeps the block in IDLE with the initial layout. RUN resumes on the first tick with `restart` low and `enable` high.
- `reset` mid-operation clears every register at the next edge, including a pending pulse.
- `random` is sampled only on recycle ticks; no handshake is required.

## Structure
- Shared `flappy_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, RUN, HALT} sched_state_t`;
  - `COORD_W=11`, `SCREEN_W`, `PIPE_W`, `BIRD_X`;
  - the initial-layout constants, which `collision_detector` and `display_manager` reuse.
- One sub-module, `pipe_lane`, is instantiated twice. It contains one pipe's x/y registers, the recycle/move logic, the gap mapper and crossing detection. Its outputs are `x`, `y` and `scored`.
- The top-level module holds the FSM, the score adder/saturator and the speed counter.

## Test plan
- Reset, then `enable`=1 for 5 ticks → `pipe1_x`=314, `pipe2_x`=634, `speed`=1, `running`=1.
- Start with `pipe1_x`=61 at `speed`=1, then one tick → `pipe1_x`=60 with no pulse. Next tick → `pipe1_x`=59, `score_pulse`=1, `score`=1.
- Start with `pipe1_x`=2, `speed`=2, `random`=10'h1FF → recycle: `pipe1_x`=639 and `pipe1_y`=80+(511-301)=290. Sweep `random` over all values → `pipe1_y` always in [80,380].
- Collision in RUN → HALT: positions frozen for 10 ticks with `enable`=1. Then `restart` → initial layout and `score`=0.
- Force `score` 9→10 → `speed`=2 the following tick. Continue to 40+ → `speed` holds at 4. Score stops at 999.
- Both pipes at x ≤ `speed` in the same tick → both become 639, with `pipe1_y` ≠ `pipe2_y` for `random`=10'h155.
